// File: rtl/wash_pkg.sv
// Shared opcodes, state encoding and instruction field positions for the
// wash_core sequencer.
package wash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SLEEP = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [7:0] OP_HALT     = 8'h00;
    localparam logic [7:0] OP_WAIT     = 8'h10;
    localparam logic [7:0] OP_ACT_BASE = 8'h11;
    localparam logic [7:0] OP_ACT_LAST = 8'h1F;
    localparam logic [7:0] OP_SET      = 8'h21;
    localparam logic [7:0] OP_DEC      = 8'h22;
    localparam logic [7:0] OP_J        = 8'h30;
    localparam logic [7:0] OP_JZ       = 8'h31;
    localparam logic [7:0] OP_JNZ      = 8'h32;
    localparam logic [7:0] OP_CALL     = 8'h33;
    localparam logic [7:0] OP_RET      = 8'h34;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 7;
    localparam int RID_LSB = 8;
    localparam int RID_MSB = 15;
    localparam int ARG_LSB = 16;
    localparam int ARG_MSB = 31;

endpackage

// File: rtl/wash_if.sv
// Control/fetch/status bundle between the program side and the wash_core sequencer.
interface wash_if #(
    parameter int ADDR_W  = 8,
    parameter int ACT_NUM = 4
);
    logic                start;
    logic                pause;
    logic                abort;
    logic [31:0]         instr;
    logic [ADDR_W-1:0]   pc;
    logic [ACT_NUM-1:0]  act;
    logic [7:0]          phase;
    logic [1:0]          state;
    logic                fault;

    modport master (
        output start, pause, abort, instr,
        input  pc, act, phase, state, fault
    );

    modport slave (
        input  start, pause, abort, instr,
        output pc, act, phase, state, fault
    );
endinterface

// File: rtl/wash_timer.sv
// Down-counter for timed ops: load, freeze, clear, and an expiry flag on the last count.
module wash_timer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_val,
    input  logic              i_freeze,
    input  logic              i_clear,
    output logic              o_expire
);
    logic [DATA_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (!i_freeze && r_cnt != '0)
            r_cnt <= r_cnt - DATA_W'(1);
    end

    assign o_expire = (r_cnt == DATA_W'(1));
endmodule

// File: rtl/wash_core.sv
// Program-ROM driven washer sequencer: timed actuator ops, general registers,
// call/return stack, pause/abort controls and a sticky FAULT state.
module wash_core
    import wash_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int REG_NUM     = 4,
    parameter int ADDR_W      = 8,
    parameter int ACT_NUM     = 4,
    parameter int STACK_DEPTH = 4,
    parameter int BOOT_ADDR   = 2,
    parameter int SIG_REG     = 2
) (
    input  logic  clk,
    input  logic  rst,
    wash_if.slave bus
);
    localparam int RID_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int STK_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_fault;
    logic [DATA_W-1:0]  r_regs  [REG_NUM];
    logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];
    logic [SP_W-1:0]    r_sp;

    logic [7:0]         w_opc;
    logic [7:0]         w_rid;
    logic [15:0]        w_arg;
    logic [RID_W-1:0]   w_ridx;
    logic [7:0]         w_aidx;
    logic               w_rid_ok;
    logic               w_act_ok;
    logic               w_timed;
    logic               w_short;
    logic               w_illegal;
    logic [DATA_W-1:0]  w_rval;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_target;
    logic [STK_W-1:0]   w_push_idx;
    logic [STK_W-1:0]   w_pop_idx;
    logic               w_live;
    logic               w_tmr_load;
    logic               w_expire;

    assign w_opc      = bus.instr[OPC_MSB:OPC_LSB];
    assign w_rid      = bus.instr[RID_MSB:RID_LSB];
    assign w_arg      = bus.instr[ARG_MSB:ARG_LSB];
    assign w_ridx     = w_rid[RID_W-1:0];
    assign w_aidx     = w_opc - OP_ACT_BASE;
    assign w_rid_ok   = (32'(w_rid) < REG_NUM);
    assign w_act_ok   = (w_opc >= OP_ACT_BASE) && (w_opc <= OP_ACT_LAST) && (32'(w_aidx) < ACT_NUM);
    assign w_timed    = (w_opc == OP_WAIT) || w_act_ok;
    assign w_short    = (w_arg < 16'd2);
    assign w_rval     = r_regs[w_ridx];
    assign w_pc_inc   = r_pc + ADDR_W'(1);
    assign w_target   = ADDR_W'(w_arg);
    assign w_push_idx = STK_W'(r_sp);
    assign w_pop_idx  = STK_W'(r_sp - SP_W'(1));

    always_comb begin
        w_illegal = 1'b0;
        case (w_opc)
            OP_HALT, OP_WAIT, OP_J:         w_illegal = 1'b0;
            OP_SET, OP_DEC, OP_JZ, OP_JNZ:  w_illegal = !w_rid_ok;
            OP_CALL:                        w_illegal = (r_sp == SP_W'(STACK_DEPTH));
            OP_RET:                         w_illegal = (r_sp == '0);
            default:                        w_illegal = !w_act_ok;
        endcase
    end

    // The RUN cycle is the first cycle of a timed op, so SLEEP covers arg-1 more.
    assign w_tmr_load = (r_state == ST_RUN) && !bus.pause && !bus.abort &&
                        !w_illegal && w_timed && !w_short;

    wash_timer #(.DATA_W(DATA_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (DATA_W'(w_arg) - DATA_W'(1)),
        .i_freeze   (bus.pause),
        .i_clear    (bus.abort),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_fault <= 1'b0;
            r_sp    <= '0;
            for (int i = 0; i < REG_NUM; i++)     r_regs[i]  <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else if (bus.abort) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b0;
            r_sp    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.start) begin
                    r_pc    <= ADDR_W'(BOOT_ADDR);
                    r_state <= ST_RUN;
                end
                ST_FAULT: if (bus.start) begin
                    r_sp    <= '0;
                    r_pc    <= ADDR_W'(BOOT_ADDR);
                    r_state <= ST_RUN;
                    r_fault <= 1'b0;
                end
                ST_SLEEP: if (!bus.pause && w_expire) begin
                    r_pc    <= w_pc_inc;
                    r_state <= ST_RUN;
                end
                ST_RUN: if (!bus.pause) begin
                    if (w_illegal) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        case (w_opc)
                            OP_HALT: r_state <= ST_IDLE;
                            OP_SET: begin
                                r_regs[w_ridx] <= DATA_W'(w_arg);
                                r_pc           <= w_pc_inc;
                            end
                            OP_DEC: begin
                                if (w_rval != '0) r_regs[w_ridx] <= w_rval - DATA_W'(1);
                                r_pc <= w_pc_inc;
                            end
                            OP_J:   r_pc <= w_target;
                            OP_JZ:  r_pc <= (w_rval == '0) ? w_target : w_pc_inc;
                            OP_JNZ: r_pc <= (w_rval != '0) ? w_target : w_pc_inc;
                            OP_CALL: begin
                                r_stack[w_push_idx] <= w_pc_inc;
                                r_sp                <= r_sp + SP_W'(1);
                                r_pc                <= w_target;
                            end
                            OP_RET: begin
                                r_pc <= r_stack[w_pop_idx];
                                r_sp <= r_sp - SP_W'(1);
                            end
                            default: begin
                                if (w_short) r_pc <= w_pc_inc;
                                else         r_state <= ST_SLEEP;
                            end
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_live = ((r_state == ST_RUN) || (r_state == ST_SLEEP)) && !bus.pause;

    for (genvar k = 0; k < ACT_NUM; k++) begin : g_act
        assign bus.act[k] = w_live && (w_opc == 8'(OP_ACT_BASE + k));
    end

    assign bus.pc    = r_pc;
    assign bus.state = r_state;
    assign bus.fault = r_fault;
    assign bus.phase = 8'(r_regs[SIG_REG]);
endmodule
